// File: rtl/arb_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// arb_pkg : state encoding, timer addresses and size codes for ram_rr_arbiter
// Rev 1.0
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_TMR  = 2'd3;

    localparam logic [63:0] ADDR_MTIME    = 64'h0000_0000_0200_BFF8;
    localparam logic [63:0] ADDR_MTIMECMP = 64'h0000_0000_0200_4000;

    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;
    localparam logic [2:0] SIZE_D = 3'd3;

endpackage
`default_nettype wire

// File: rtl/ram_rr_arbiter_rr_pick.sv
`default_nettype none
// -----------------------------------------------------------------------------
// rr_pick : combinational round-robin selector (first requester at/after ptr)
// Rev 1.0
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N_MST = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_MST-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_MST-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < N_MST; i++) begin
            // One spare bit so ptr+i can exceed N_MST before wrapping
            pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N_MST)) begin
                pos = pos - (IDX_W+1)'(N_MST);
            end
            if (!found && req_i[pos[IDX_W-1:0]]) begin
                found                   = 1'b1;
                grant_o[pos[IDX_W-1:0]] = 1'b1;
                idx_o                   = pos[IDX_W-1:0];
            end
        end
        any_o = found;
    end

endmodule
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ram_rr_arbiter : round-robin arbiter of N_MST masters onto one RAM port;
// define ARB_TIMER_EN to divert MTIME/MTIMECMP accesses to the timer port.
// Rev 1.0
// -----------------------------------------------------------------------------
module ram_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_MST-1:0]         m_cen_i,
    input  logic [N_MST-1:0]         m_wen_i,
    input  logic [N_MST*ADDR_W-1:0]  m_addr_i,
    input  logic [N_MST*3-1:0]       m_size_i,
    input  logic [N_MST*DATA_W-1:0]  m_wdata_i,
    output logic [N_MST-1:0]         m_valid_o,
    output logic [DATA_W-1:0]        m_rdata_o,
`ifdef ARB_TIMER_EN
    output logic                     ram_timer_cen_o,
    output logic                     ram_timer_wen_o,
    output logic [ADDR_W-1:0]        ram_timer_addr_o,
    output logic [DATA_W-1:0]        ram_timer_wdata_o,
    input  logic [DATA_W-1:0]        timer_rdata_i,
`endif
    output logic                     ram_rw_cen_o,
    output logic                     ram_rw_wen_o,
    output logic [ADDR_W-1:0]        ram_rw_addr_o,
    output logic [DATA_W-1:0]        ram_rw_wdata_o,
    output logic [2:0]               ram_rw_size_o,
    input  logic                     ram_rw_ready_i,
    input  logic [DATA_W-1:0]        ram_rw_data_i
);

    localparam int IDX_W = $clog2(N_MST);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    logic [N_MST-1:0]  grant_q, grant_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [N_MST-1:0]  w_pick_grant;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_done;
    logic              w_rw_act;

    rr_pick #(
        .N_MST (N_MST),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (m_cen_i),
        .ptr_i   (ptr_q),
        .grant_o (w_pick_grant),
        .idx_o   (w_pick_idx),
        .any_o   (w_pick_any)
    );

    assign w_sel_addr = m_addr_i[int'(w_pick_idx)*ADDR_W +: ADDR_W];
    assign w_rw_act   = (state_q == ST_REQ) || (state_q == ST_WAIT);

`ifdef ARB_TIMER_EN
    logic w_is_tmr;
    assign w_is_tmr = (w_sel_addr == ADDR_W'(ADDR_MTIME)) || (w_sel_addr == ADDR_W'(ADDR_MTIMECMP));
    assign w_done   = ((state_q == ST_WAIT) && ram_rw_ready_i) || (state_q == ST_TMR);
`else
    assign w_done   = (state_q == ST_WAIT) && ram_rw_ready_i;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pick_any) begin
                    gidx_d  = w_pick_idx;
                    grant_d = w_pick_grant;
                    wen_d   = m_wen_i[w_pick_idx];
                    addr_d  = w_sel_addr;
                    size_d  = m_size_i[int'(w_pick_idx)*3 +: 3];
                    wdata_d = m_wdata_i[int'(w_pick_idx)*DATA_W +: DATA_W];
`ifdef ARB_TIMER_EN
                    state_d = w_is_tmr ? ST_TMR : ST_REQ;
`else
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ:  state_d = ST_WAIT;
            ST_WAIT: if (ram_rw_ready_i) state_d = ST_IDLE;
`ifdef ARB_TIMER_EN
            ST_TMR:  state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
        // Pointer moves past the master just served, so it goes last next round
        if (w_done) begin
            ptr_d = (gidx_q == IDX_W'(N_MST-1)) ? '0 : gidx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    assign ram_rw_cen_o   = w_rw_act;
    assign ram_rw_wen_o   = w_rw_act & wen_q;
    assign ram_rw_addr_o  = w_rw_act ? addr_q  : '0;
    assign ram_rw_wdata_o = w_rw_act ? wdata_q : '0;
    assign ram_rw_size_o  = w_rw_act ? size_q  : '0;
    assign m_valid_o      = w_done ? grant_q : '0;

`ifdef ARB_TIMER_EN
    assign ram_timer_cen_o   = (state_q == ST_TMR);
    assign ram_timer_wen_o   = (state_q == ST_TMR) & wen_q;
    assign ram_timer_addr_o  = (state_q == ST_TMR) ? addr_q  : '0;
    assign ram_timer_wdata_o = (state_q == ST_TMR) ? wdata_q : '0;
    assign m_rdata_o = (state_q == ST_TMR) ? timer_rdata_i :
                       (w_done ? ram_rw_data_i : '0);
`else
    assign m_rdata_o = w_done ? ram_rw_data_i : '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ram_rr_arbiter : table vectors plus hand sequences, checked by scoreboard
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_ram_rr_arbiter;
    import arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam logic [63:0] RD_XOR   = 64'h5A5A_0F0F_C3C3_9696;
    localparam logic [63:0] TMR_DATA = 64'h0000_1234_5678_9ABC;
`ifdef ARB_TIMER_EN
    localparam int TL0 = 1;
    localparam int TL2 = 1;
`else
    localparam int TL0 = 2;
    localparam int TL2 = 4;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    m_cen, m_wen, m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*3-1:0]  m_size;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            rw_cen, rw_wen, rw_ready;
    logic [AW-1:0]   rw_addr;
    logic [DW-1:0]   rw_wdata, rw_data;
    logic [2:0]      rw_size;
`ifdef ARB_TIMER_EN
    logic            t_cen, t_wen;
    logic [AW-1:0]   t_addr;
    logic [DW-1:0]   t_wdata, t_rdata;
    assign t_rdata = TMR_DATA;
`endif

    always #5 clk = ~clk;

    ram_rr_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m_cen_i          (m_cen),
        .m_wen_i          (m_wen),
        .m_addr_i         (m_addr),
        .m_size_i         (m_size),
        .m_wdata_i        (m_wdata),
        .m_valid_o        (m_valid),
        .m_rdata_o        (m_rdata),
`ifdef ARB_TIMER_EN
        .ram_timer_cen_o  (t_cen),
        .ram_timer_wen_o  (t_wen),
        .ram_timer_addr_o (t_addr),
        .ram_timer_wdata_o(t_wdata),
        .timer_rdata_i    (t_rdata),
`endif
        .ram_rw_cen_o     (rw_cen),
        .ram_rw_wen_o     (rw_wen),
        .ram_rw_addr_o    (rw_addr),
        .ram_rw_wdata_o   (rw_wdata),
        .ram_rw_size_o    (rw_size),
        .ram_rw_ready_i   (rw_ready),
        .ram_rw_data_i    (rw_data)
    );

    typedef struct {
        int          idx;
        logic        wen;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          issue_cyc;
        int          lat;
    } exp_t;

    typedef struct {
        int          idx;
        logic        wen;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        int          ram_lat;
        int          exp_lat;
    } vec_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, cyc = 0, done_cnt = 0, ram_lat = 0, cnt = 0;

    // RAM model: ready after ram_lat extra WAIT cycles, data derived from address
    assign rw_data  = rw_addr ^ RD_XOR;
    assign rw_ready = rw_cen && (cnt > ram_lat);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt <= 0;
        else if (rw_cen) cnt <= cnt + 1;
        else             cnt <= 0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        if (rw_cen) begin
            if (sb.size() > 0) begin
                chk("rw_addr_held", rw_addr, sb[0].addr);
                chk("rw_wdata", rw_wdata, sb[0].wdata);
                chk("rw_wen_size", {60'd0, rw_wen, rw_size}, {60'd0, sb[0].wen, sb[0].size});
            end
        end else begin
            chk("rw_idle_zero", rw_addr | rw_wdata | {60'd0, rw_wen, rw_size}, 64'd0);
        end
`ifdef ARB_TIMER_EN
        if (t_cen) begin
            chk("tmr_rw_cen_off", {63'd0, rw_cen}, 64'd0);
            if (sb.size() > 0) begin
                chk("tmr_addr", t_addr, sb[0].addr);
                chk("tmr_wdata", t_wdata, sb[0].wdata);
                chk("tmr_wen", {63'd0, t_wen}, {63'd0, sb[0].wen});
            end
        end
`endif
        if (m_valid != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got %b, expected none", m_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("valid_grant", 64'(m_valid), 64'(1) << e.idx);
                chk("rdata", m_rdata, e.rdata);
                if (e.lat >= 0) chk("latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
            end
            m_cen = m_cen & ~m_valid;
            done_cnt++;
        end else begin
            chk("rdata_idle_zero", m_rdata, 64'd0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic issue(input int k, input logic wen, input logic [63:0] addr,
                         input logic [2:0] size, input logic [63:0] wdata);
        m_cen[k]             = 1'b1;
        m_wen[k]             = wen;
        m_addr[k*AW +: AW]   = addr;
        m_size[k*3 +: 3]     = size;
        m_wdata[k*DW +: DW]  = wdata;
    endtask

    task automatic push(input int k, input logic wen, input logic [63:0] addr,
                        input logic [2:0] size, input logic [63:0] wdata, input int lat);
        exp_t e;
        e.idx = k; e.wen = wen; e.addr = addr; e.size = size; e.wdata = wdata;
        e.rdata = addr ^ RD_XOR;
`ifdef ARB_TIMER_EN
        if (addr == ADDR_MTIME || addr == ADDR_MTIMECMP) e.rdata = TMR_DATA;
`endif
        e.issue_cyc = cyc;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL timeout: got %0d completions, expected %0d", done_cnt, target);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_cen = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t vt[6];

    initial begin
        int base;
        vt[0] = '{0, 1'b0, 64'h0000_0000_8000_0000, SIZE_D, 64'h0, 1, 3};
        vt[1] = '{1, 1'b1, 64'h0000_0000_8000_1000, SIZE_W, 64'hDEAD_BEEF_0000_1111, 0, 2};
        vt[2] = '{3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, SIZE_D, 64'h0, 3, 5};
        vt[3] = '{2, 1'b1, 64'h0, SIZE_B, 64'hFF, 0, 2};
        vt[4] = '{1, 1'b1, ADDR_MTIMECMP, SIZE_D, 64'h64, 0, TL0};
        vt[5] = '{0, 1'b0, ADDR_MTIME, SIZE_D, 64'h0, 2, TL2};

        m_cen = '0; m_wen = '0; m_addr = '0; m_size = '0; m_wdata = '0;

        // Reset state, including pending requests that must not be served
        #12;
        m_cen = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rw_cen", {63'd0, rw_cen}, 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_rdata", m_rdata, 64'd0);
        chk("rst_rw_addr", rw_addr, 64'd0);
`ifdef ARB_TIMER_EN
        chk("rst_tmr_cen", {63'd0, t_cen}, 64'd0);
`endif
        m_cen = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Masters 0 and 1 together with pointer at 0: m0 first, then m1
        ram_lat = 0;
        base = done_cnt;
        issue(0, 1'b0, 64'h1000, SIZE_D, 64'h0);
        issue(1, 1'b0, 64'h2000, SIZE_D, 64'h0);
        push(0, 1'b0, 64'h1000, SIZE_D, 64'h0, 2);
        push(1, 1'b0, 64'h2000, SIZE_D, 64'h0, 5);
        wait_done(base + 2, 30);
        step();

        // Pointer now 2: m1 and m3 together must wrap to serve m3 first
        base = done_cnt;
        issue(1, 1'b1, 64'h3000, SIZE_W, 64'h11);
        issue(3, 1'b1, 64'h4000, SIZE_H, 64'h33);
        push(3, 1'b1, 64'h4000, SIZE_H, 64'h33, 2);
        push(1, 1'b1, 64'h3000, SIZE_W, 64'h11, 5);
        wait_done(base + 2, 30);
        step();

        for (int i = 0; i < 6; i++) begin
            ram_lat = vt[i].ram_lat;
            base = done_cnt;
            issue(vt[i].idx, vt[i].wen, vt[i].addr, vt[i].size, vt[i].wdata);
            push(vt[i].idx, vt[i].wen, vt[i].addr, vt[i].size, vt[i].wdata, vt[i].exp_lat);
            wait_done(base + 1, 30);
            step();
        end

        // Master changes its request fields while waiting on the RAM
        ram_lat = 4;
        base = done_cnt;
        issue(2, 1'b1, 64'h0000_0000_8000_2000, SIZE_D, 64'hCAFE);
        push(2, 1'b1, 64'h0000_0000_8000_2000, SIZE_D, 64'hCAFE, 6);
        repeat (3) step();
        m_addr[2*AW +: AW]  = 64'h0000_0000_9999_0000;
        m_wdata[2*DW +: DW] = 64'hBAD0;
        m_wen[2]            = 1'b0;
        wait_done(base + 1, 30);
        step();

        // Reset in the middle of WAIT abandons the transaction
        ram_lat = 6;
        issue(3, 1'b0, 64'h0000_0000_8000_3000, SIZE_D, 64'h0);
        push(3, 1'b0, 64'h0000_0000_8000_3000, SIZE_D, 64'h0, -1);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rw_cen", {63'd0, rw_cen}, 64'd0);
        chk("rst_async_valid", 64'(m_valid), 64'd0);
        m_cen = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = done_cnt;
        repeat (8) step();
        chk("no_valid_after_rst", 64'(done_cnt), 64'(base));

        // All four masters request continuously from pointer 0
        do_reset();
        ram_lat = 0;
        base = done_cnt;
        for (int k = 0; k < N; k++) issue(k, 1'b0, 64'h100 * (k + 1), SIZE_D, 64'h0);
        for (int k = 0; k < N; k++) push(k, 1'b0, 64'h100 * (k + 1), SIZE_D, 64'h0, (k == 0) ? 2 : -1);
        push(0, 1'b0, 64'h100, SIZE_D, 64'h0, -1);
        wait_done(base + 1, 30);
        issue(0, 1'b0, 64'h100, SIZE_D, 64'h0);
        wait_done(base + 5, 60);
        repeat (2) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
